// File: rtl/branch_predictor_pkg.sv
// Shared constants for the IF-stage branch predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - counter value after reset and on allocation
//   - pipeline NOP encoding used by the pipeline registers
package branch_predictor_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] CNT_RESET = CNT_WNT;
  localparam logic [1:0] CNT_ALLOC = CNT_WT;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: combinational next-state function of a 2-bit saturating
// branch counter.
//   cnt_i   : current counter state
//   taken_i : resolved branch outcome
//   cnt_o   : next counter state (saturates at SNT and ST)
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       taken_i,
  output logic [1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit saturating counter per
// entry. Lookup is combinational on IF_pc; training is registered from the
// EX-stage update port.
//   clk, reset        : clock (rising edge), async active-high reset
//   IF_pc             : current fetch PC
//   branch_estimation : predicted taken for IF_pc
//   predicted_pc      : next fetch PC (target on predicted taken, else PC+4)
//   update_valid      : EX resolved a conditional branch this cycle
//   update_pc         : PC of the resolved branch
//   update_taken      : actual outcome
//   update_target     : actual taken target
// ENTRIES must be a power of two, at least 4.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] IF_pc,
  output logic            branch_estimation,
  output logic [XLEN-1:0] predicted_pc,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_W      = XLEN - INDEX_BITS - 2;

  // Table storage: flops, so the whole table clears asynchronously.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [XLEN-1:0]   target_d [ENTRIES];
  logic [1:0]        cnt_d    [ENTRIES];

  // Byte-offset bits are don't-care for word-aligned fetch.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_pc[1:0], update_pc[1:0]};

  // Lookup
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic                  if_hit;

  assign if_idx = IF_pc[INDEX_BITS+1:2];
  assign if_tag = IF_pc[XLEN-1:INDEX_BITS+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // No bypass from the update port: a same-cycle update to the looked-up
  // entry becomes visible only after the clock edge.
  assign branch_estimation = if_hit && cnt_q[if_idx][1];
  assign predicted_pc      = branch_estimation ? target_q[if_idx]
                                               : IF_pc + XLEN'(4);

  // Update
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic [1:0]            up_cnt_nxt;

  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag = update_pc[XLEN-1:INDEX_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter2 u_sat_counter2 (
    .cnt_i   (cnt_q[up_idx]),
    .taken_i (update_taken),
    .cnt_o   (up_cnt_nxt)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (update_valid) begin
      if (up_hit) begin
        // Resident entry trains in place; a not-taken hit keeps it resident.
        cnt_d[up_idx] = up_cnt_nxt;
        if (update_taken) target_d[up_idx] = update_target;
      end else if (update_taken) begin
        // Taken miss evicts whatever occupies the slot.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = update_target;
        cnt_d[up_idx]    = CNT_ALLOC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            clk_en = 1'b1;
  logic            reset;
  logic [XLEN-1:0] IF_pc;
  logic            branch_estimation;
  logic [XLEN-1:0] predicted_pc;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(64)) dut (
    .clk               (clk),
    .reset             (reset),
    .IF_pc             (IF_pc),
    .branch_estimation (branch_estimation),
    .predicted_pc      (predicted_pc),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target)
  );

  // Gateable clock so reset can be exercised with no edges.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic            uv;
    logic [XLEN-1:0] upc;
    logic            ut;
    logic [XLEN-1:0] utgt;
    logic [XLEN-1:0] ifpc;
    logic            est;
    logic [XLEN-1:0] ppc;
  } vec_t;

  typedef struct {
    int              id;
    logic            est;
    logic [XLEN-1:0] ppc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic uv, logic [XLEN-1:0] upc, logic ut,
                              logic [XLEN-1:0] utgt, logic [XLEN-1:0] ifpc,
                              logic est, logic [XLEN-1:0] ppc);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.ifpc = ifpc; v.est = est; v.ppc = ppc;
    return v;
  endfunction

  task automatic drive(logic uv, logic [XLEN-1:0] upc, logic ut,
                       logic [XLEN-1:0] utgt, logic [XLEN-1:0] ifpc);
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    IF_pc         = ifpc;
  endtask

  task automatic expect_out(int id, logic est, logic [XLEN-1:0] ppc);
    exp_t e;
    e.id = id; e.est = est; e.ppc = ppc;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare with the current outputs.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty got none required entry");
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (branch_estimation !== e.est || predicted_pc !== e.ppc) begin
      n_err++;
      $display("FAIL vec%0d est got %0b want %0b, pc got %h want %h",
               e.id, branch_estimation, e.est, predicted_pc, e.ppc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // id 0..23: table vectors; 100+: hand sequences
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104)); // 0 reset state
    vecs.push_back(mk(1, 32'h100, 1, 32'h80,  32'h100, 0, 32'h104)); // 1 same-cycle, no bypass
    vecs.push_back(mk(1, 32'h100, 1, 32'h80,  32'h100, 1, 32'h80));  // 2 WT -> ST
    vecs.push_back(mk(1, 32'h100, 1, 32'h80,  32'h100, 1, 32'h80));  // 3 ST stays ST
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,   32'h100, 1, 32'h80));  // 4 ST -> WT
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,   32'h100, 1, 32'h80));  // 5 WT -> WNT
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,   32'h100, 0, 32'h104)); // 6 WNT -> SNT
    vecs.push_back(mk(1, 32'h100, 0, 32'h0,   32'h100, 0, 32'h104)); // 7 SNT stays
    vecs.push_back(mk(1, 32'h100, 1, 32'h80,  32'h100, 0, 32'h104)); // 8 SNT -> WNT
    vecs.push_back(mk(1, 32'h100, 1, 32'h80,  32'h100, 0, 32'h104)); // 9 WNT (resident) -> WT
    vecs.push_back(mk(1, 32'h100, 1, 32'h80,  32'h100, 1, 32'h80));  // 10 WT -> ST
    vecs.push_back(mk(1, 32'h200, 0, 32'h0,   32'h200, 0, 32'h204)); // 11 alias miss, NT
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h80));  // 12 0x100 intact
    vecs.push_back(mk(1, 32'h200, 1, 32'h40,  32'h200, 0, 32'h204)); // 13 evict
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h200, 1, 32'h40));  // 14
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104)); // 15 evicted
    vecs.push_back(mk(1, 32'h200, 1, 32'h60,  32'h200, 1, 32'h40));  // 16 hit taken new target
    vecs.push_back(mk(1, 32'h104, 1, 32'h300, 32'h202, 1, 32'h60));  // 17 pc[1:0] ignored
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h104, 1, 32'h300)); // 18 index 1
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h200, 1, 32'h60));  // 19
    vecs.push_back(mk(0, 32'h300, 1, 32'h10,  32'h300, 0, 32'h304)); // 20 uv=0 ignored
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h300, 0, 32'h304)); // 21
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'h200, 1, 32'h60));  // 22
    vecs.push_back(mk(0, 32'h0,   0, 32'h0,   32'hFFFF_FFFC, 0, 32'h0)); // 23 wrap

    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h100);
    #2;
    expect_out(100, 0, 32'h104);
    check_out();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].ifpc);
      expect_out(i, vecs[i].est, vecs[i].ppc);
      #1 check_out();
    end

    // Train 0x100 to ST (evicts 0x200), then clear with the clock stopped.
    @(negedge clk); drive(1, 32'h100, 1, 32'h80, 32'h100);
    @(negedge clk); drive(1, 32'h100, 1, 32'h80, 32'h100);
    @(negedge clk); drive(0, 0, 0, 0, 32'h100);
    expect_out(101, 1, 32'h80);
    #1 check_out();
    clk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    expect_out(102, 0, 32'h104);
    check_out();
    #4 reset = 1'b0;
    #1;
    expect_out(103, 0, 32'h104);
    check_out();
    clk_en = 1'b1;
    @(negedge clk); drive(0, 32'h100, 1, 32'h80, 32'h100);
    @(negedge clk);
    expect_out(104, 0, 32'h104);
    #1 check_out();
    IF_pc = 32'h104;
    expect_out(105, 0, 32'h108);
    #1 check_out();
    IF_pc = 32'h200;
    expect_out(106, 0, 32'h204);
    #1 check_out();

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
